// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
//
// Watches a multiplexed, active-low 7-segment display bus and recovers the BCD
// digits being shown. Each digit strobe must hold a constant segment pattern
// for SETTLE registered samples before it is captured. The decoded digit goes
// into a staging slot. Once every digit has been captured, the staging slots
// are published as one frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   seg_n        segment lines, active-low, {g,f,e,d,c,b,a}
//   an_n         digit strobes, active-low, one-hot when valid; bit 0 = rightmost
//   bcd_frame    decoded digits, digit i at [4i+3:4i]
//   seg_err      per-digit flag: last captured pattern was not a legal code
//   frame_valid  one-cycle pulse when bcd_frame / seg_err update
//   onehot_err   one-cycle pulse for each sample with more than one strobe low
//   stall        level: no capture for TIMEOUT cycles
// -----------------------------------------------------------------------------
module seg7_scan_capture #(
    parameter int NUM_DIGITS = 6,
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] bcd_frame,
    output logic [NUM_DIGITS-1:0]   seg_err,
    output logic                    frame_valid,
    output logic                    onehot_err,
    output logic                    stall
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [TMO_W-1:0] TIMEOUT_C = TMO_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Input sampling. The second register pair holds the previous sample,
    // so the design can tell whether the bus is holding still.
    // ------------------------------------------------------------------
    logic [6:0]            r_seg_q;
    logic [NUM_DIGITS-1:0] r_an_q;
    logic [6:0]            p_seg_q;
    logic [NUM_DIGITS-1:0] p_an_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q <= '1;
            r_an_q  <= '1;
            p_seg_q <= '1;
            p_an_q  <= '1;
        end else begin
            r_seg_q <= seg_n;
            r_an_q  <= an_n;
            p_seg_q <= r_seg_q;
            p_an_q  <= r_an_q;
        end
    end

    // ------------------------------------------------------------------
    // Strobe classification (active-high copy of the strobes)
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] strobe;
    logic                  strobe_idle;
    logic                  strobe_one;
    logic                  strobe_bad;
    logic                  bus_changed;

    assign strobe      = ~r_an_q;
    assign strobe_idle = (strobe == '0);
    // x & (x-1) clears the lowest set bit, so the result is zero only for a
    // single-hot (or zero) vector.
    assign strobe_one  = !strobe_idle &&
                         ((strobe & (strobe - NUM_DIGITS'(1))) == '0);
    assign strobe_bad  = !strobe_idle && !strobe_one;
    assign bus_changed = ({r_an_q, r_seg_q} != {p_an_q, p_seg_q});

    // ------------------------------------------------------------------
    // Stability counter and capture-done flag
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             capture;

    always_comb begin
        cnt_d = '0;
        if (strobe_one) begin
            if (bus_changed) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == SETTLE_C) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The done flag stops a long dwell from capturing again once the
    // counter has saturated. Only a change on the bus re-arms capture.
    assign capture = (cnt_d == SETTLE_C) && (cnt_q != SETTLE_C) && !done_q;

    always_comb begin
        done_d = done_q;
        if (bus_changed) begin
            done_d = 1'b0;
        end else if (capture) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Segment pattern decode
    // ------------------------------------------------------------------
    logic [3:0] dec_val;
    logic       dec_err;

    always_comb begin
        dec_val = 4'hE;
        dec_err = 1'b1;
        case (r_seg_q)
            7'b1000000: begin dec_val = 4'd0; dec_err = 1'b0; end
            7'b1111001: begin dec_val = 4'd1; dec_err = 1'b0; end
            7'b0100100: begin dec_val = 4'd2; dec_err = 1'b0; end
            7'b0110000: begin dec_val = 4'd3; dec_err = 1'b0; end
            7'b0011001: begin dec_val = 4'd4; dec_err = 1'b0; end
            7'b0010010: begin dec_val = 4'd5; dec_err = 1'b0; end
            7'b0000010: begin dec_val = 4'd6; dec_err = 1'b0; end
            7'b1111000: begin dec_val = 4'd7; dec_err = 1'b0; end
            7'b0000000: begin dec_val = 4'd8; dec_err = 1'b0; end
            7'b0010000: begin dec_val = 4'd9; dec_err = 1'b0; end
            7'b1111111: begin dec_val = 4'hF; dec_err = 1'b0; end
            default:    begin dec_val = 4'hE; dec_err = 1'b1; end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-digit staging slots. A slot is written whenever its digit is
    // captured. A repeated capture before the frame completes overwrites it.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] stage_bcd;
    logic [NUM_DIGITS-1:0]   stage_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] slot_bcd_q;
            logic       slot_err_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_bcd_q <= 4'hF;
                    slot_err_q <= 1'b0;
                end else if (capture && strobe[gi]) begin
                    slot_bcd_q <= dec_val;
                    slot_err_q <= dec_err;
                end
            end

            assign stage_bcd[4*gi +: 4] = slot_bcd_q;
            assign stage_err[gi]        = slot_err_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame assembly and stall supervision
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  tmo_hit;
    logic                  frame_copy;
    logic                  stall_q, stall_d;

    // Publish on the cycle after the last digit is seen. The staging read
    // here is the pre-capture value, so a capture on this same cycle lands
    // in the next frame.
    assign frame_copy = &seen_q;

    always_comb begin
        tmo_d = tmo_q;
        if (capture) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_C) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (tmo_d == TIMEOUT_C);

    always_comb begin
        seen_d = seen_q;
        // A timeout discards the partial frame. A copy starts a new frame.
        if (frame_copy || tmo_hit) begin
            seen_d = '0;
        end
        if (capture) begin
            seen_d = seen_d | strobe;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (capture) begin
            stall_d = 1'b0;
        end else if (tmo_hit) begin
            stall_d = 1'b1;
        end
    end

    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    fv_q;
    logic                    oh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q  <= '0;
            tmo_q   <= '0;
            stall_q <= 1'b0;
            bcd_q   <= '1;
            err_q   <= '0;
            fv_q    <= 1'b0;
            oh_q    <= 1'b0;
        end else begin
            seen_q  <= seen_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            fv_q    <= frame_copy;
            oh_q    <= strobe_bad;
            if (frame_copy) begin
                bcd_q <= stage_bcd;
                err_q <= stage_err;
            end
        end
    end

    assign bcd_frame   = bcd_q;
    assign seg_err     = err_q;
    assign frame_valid = fv_q;
    assign onehot_err  = oh_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// Testbench for seg7_scan_capture.
// A reference model tracks the displayed digits per dwell. It queues each
// frame that should complete. A monitor pops the queue on every frame_valid
// and compares the result with the DUT.
// -----------------------------------------------------------------------------
module tb_seg7_scan_capture;

    localparam int ND      = 6;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_n = '1;
    logic [ND-1:0] an_n = '1;
    logic [4*ND-1:0] bcd_frame;
    logic [ND-1:0]   seg_err;
    logic            frame_valid;
    logic            onehot_err;
    logic            stall;

    seg7_scan_capture #(
        .NUM_DIGITS(ND),
        .SETTLE    (SETTLE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .bcd_frame  (bcd_frame),
        .seg_err    (seg_err),
        .frame_valid(frame_valid),
        .onehot_err (onehot_err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   err;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_exp;
    int n_vec = 0;
    int n_err = 0;
    int frames_seen = 0;
    int oh_count = 0;
    logic [4*ND-1:0] last_bcd = '1;
    logic [ND-1:0]   last_err = '0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // ---------------- reference model ----------------
    logic [3:0] m_bcd [ND];
    logic       m_err [ND];
    bit         m_seen [ND];
    int         m_idle;
    bit         m_stall;

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v,
                                       output logic e);
        v = 4'hE;
        e = 1'b1;
        if (p == 7'h7F) begin
            v = 4'hF;
            e = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (p == seg_tab[k]) begin
                v = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ND; i++) begin
            m_bcd[i]  = 4'hF;
            m_err[i]  = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_idle  = 0;
        m_stall = 1'b0;
    endfunction

    function automatic void model_idle(input int n);
        m_idle += n;
        if (m_idle >= TIMEOUT) begin
            m_stall = 1'b1;
            for (int i = 0; i < ND; i++) m_seen[i] = 1'b0;
        end
    endfunction

    function automatic void model_capture(input int d, input logic [6:0] pat,
                                          input int tail);
        frame_t f;
        bit all_seen;
        logic [3:0] v;
        logic e;
        ref_decode(pat, v, e);
        m_bcd[d]  = v;
        m_err[d]  = e;
        m_seen[d] = 1'b1;
        m_stall   = 1'b0;
        m_idle    = tail;
        all_seen  = 1'b1;
        for (int i = 0; i < ND; i++) if (!m_seen[i]) all_seen = 1'b0;
        if (all_seen) begin
            for (int i = 0; i < ND; i++) begin
                f.bcd[4*i +: 4] = m_bcd[i];
                f.err[i]        = m_err[i];
                m_seen[i]       = 1'b0;
            end
            exp_q.push_back(f);
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes one expected frame per frame_valid pulse.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (onehot_err) oh_count++;
            if (frame_valid) begin
                frames_seen++;
                n_vec++;
                last_bcd = bcd_frame;
                last_err = seg_err;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame: got bcd=%h err=%b expected no frame",
                             bcd_frame, seg_err);
                end else begin
                    got_exp = exp_q.pop_front();
                    if (bcd_frame !== got_exp.bcd || seg_err !== got_exp.err) begin
                        n_err++;
                        $display("FAIL frame: got bcd=%h err=%b expected bcd=%h err=%b",
                                 bcd_frame, seg_err, got_exp.bcd, got_exp.err);
                    end else begin
                        $display("frame ok: bcd=%h err=%b", bcd_frame, seg_err);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] sc_pat [ND];
    int         sc_len [ND];

    task automatic dwell(input int d, input logic [6:0] pat, input int len);
        logic [ND-1:0] oh;
        // The model runs first, so the frame is queued before the DUT
        // can publish it.
        if (len >= SETTLE) model_capture(d, pat, len - SETTLE + 1);
        else               model_idle(len + 1);
        oh    = '0;
        oh[d] = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            seg_n = pat;
            an_n  = ~oh;
        end
        @(negedge clk);
        seg_n = '1;
        an_n  = '1;
    endtask

    task automatic run_scan();
        for (int d = 0; d < ND; d++) dwell(d, sc_pat[d], sc_len[d]);
    endtask

    task automatic idle_gap(input int n);
        model_idle(n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            seg_n = '1;
            an_n  = '1;
        end
    endtask

    task automatic onehot_burst(input int n);
        model_idle(n + 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            seg_n = seg_tab[8];
            an_n  = 6'b111100;
        end
        @(negedge clk);
        an_n  = '1;
        seg_n = '1;
    endtask

    task automatic drain(input string name);
        idle_gap(8);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        seg_n = '1;
        an_n  = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int f0;
    int oh0;
    int ord [ND];
    int j;
    int t;
    int r;
    logic [6:0] p;

    initial begin
        model_reset();
        do_reset();
        check("reset_bcd", 64'(bcd_frame), 64'hFFFFFF);
        check("reset_err", 64'(seg_err), 64'd0);
        check("reset_fv", 64'(frame_valid), 64'd0);
        check("reset_oh", 64'(onehot_err), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        // Digits 1..6 on positions 0..5
        for (int d = 0; d < ND; d++) begin
            sc_pat[d] = seg_tab[d+1];
            sc_len[d] = SETTLE + 2;
        end
        f0 = frames_seen;
        run_scan();
        drain("scan1_drain");
        check("scan1_count", 64'(frames_seen - f0), 64'd1);
        check("scan1_bcd", 64'(last_bcd), 64'h654321);
        check("scan1_err", 64'(last_err), 64'd0);

        // Blank digit 2
        for (int d = 0; d < ND; d++) begin
            sc_pat[d] = seg_tab[0];
            sc_len[d] = SETTLE + 1;
        end
        sc_pat[2] = 7'b1111111;
        run_scan();
        drain("blank_drain");
        check("blank_bcd", 64'(last_bcd), 64'h000F00);
        check("blank_err", 64'(last_err), 64'd0);

        // Illegal pattern on digit 3
        sc_pat[2] = seg_tab[0];
        sc_pat[3] = 7'b0101010;
        run_scan();
        drain("illegal_drain");
        check("illegal_bcd", 64'(last_bcd), 64'h00E000);
        check("illegal_err", 64'(last_err), 64'b001000);

        // Short dwell on digit 4 blocks the frame; SETTLE dwell completes it
        for (int d = 0; d < ND; d++) begin
            sc_pat[d] = seg_tab[(d + 3) % 10];
            sc_len[d] = SETTLE;
        end
        sc_len[4] = SETTLE - 1;
        f0 = frames_seen;
        run_scan();
        run_scan();
        drain("short_drain");
        check("short_no_frame", 64'(frames_seen - f0), 64'd0);
        sc_len[4] = SETTLE;
        run_scan();
        drain("long_drain");
        check("long_frame", 64'(frames_seen - f0), 64'd1);

        // Multi-hot strobe in the middle of a scan
        do_reset();
        for (int d = 0; d < ND; d++) begin
            sc_pat[d] = seg_tab[9 - d];
            sc_len[d] = SETTLE + 1;
        end
        f0  = frames_seen;
        oh0 = oh_count;
        for (int d = 0; d < 3; d++) dwell(d, sc_pat[d], sc_len[d]);
        onehot_burst(3);
        for (int d = 3; d < ND; d++) dwell(d, sc_pat[d], sc_len[d]);
        drain("onehot_drain");
        check("onehot_cycles", 64'(oh_count - oh0), 64'd3);
        check("onehot_frame", 64'(frames_seen - f0), 64'd1);

        // Randomized scans
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < ND; i++) ord[i] = i;
            for (int i = ND - 1; i > 0; i--) begin
                j      = int'($urandom_range(i, 0));
                t      = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
            for (int k = 0; k < ND; k++) begin
                r = int'($urandom_range(9, 0));
                if (r < 8)       p = seg_tab[$urandom_range(9, 0)];
                else if (r == 8) p = 7'h7F;
                else             p = 7'($urandom);
                dwell(ord[k], p, int'($urandom_range(SETTLE + 3, SETTLE - 1)));
            end
            if ($urandom_range(3, 0) == 0) onehot_burst(2);
        end
        drain("random_drain");
        check("random_stall", 64'(stall), 64'(m_stall));

        // Stall: three captures, then a long idle bus
        do_reset();
        for (int d = 0; d < ND; d++) begin
            sc_pat[d] = seg_tab[d];
            sc_len[d] = SETTLE + 1;
        end
        for (int d = 0; d < 3; d++) dwell(d, sc_pat[d], sc_len[d]);
        idle_gap(TIMEOUT + 40);
        check("stall_set", 64'(stall), 64'd1);
        check("stall_model", 64'(stall), 64'(m_stall));
        f0 = frames_seen;
        for (int d = 3; d < ND; d++) dwell(d, sc_pat[d], sc_len[d]);
        drain("stall_partial_drain");
        check("stall_discard", 64'(frames_seen - f0), 64'd0);
        check("stall_cleared", 64'(stall), 64'd0);
        run_scan();
        drain("stall_full_drain");
        check("stall_recover", 64'(frames_seen - f0), 64'd1);

        // Finish the pending partial frame, then reset partway through a scan
        for (int d = 0; d < 3; d++) dwell(d, sc_pat[d], sc_len[d]);
        drain("pre_rst_drain");
        for (int d = 0; d < 3; d++) dwell(d, sc_pat[d], sc_len[d]);
        do_reset();
        check("midrst_bcd", 64'(bcd_frame), 64'hFFFFFF);
        check("midrst_stall", 64'(stall), 64'd0);
        f0 = frames_seen;
        for (int d = 3; d < ND; d++) dwell(d, sc_pat[d], sc_len[d]);
        drain("midrst_drain");
        check("midrst_no_frame", 64'(frames_seen - f0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the clock's display path: monitors a multiplexed, active-low 7-segment bus (segment lines plus one-hot active-low digit strobes) and recovers the BCD digits being shown.
- Qualifies each strobe for stability, decodes the segment pattern back to BCD, and assembles a full frame across all digits.
- Used for display loop-back self-test and for bench checking of the time/date display drive.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (HH:MM:SS); legal range 2..8.
- SETTLE, 4, consecutive identical registered samples required before a digit is captured; legal range 2..255.
- TIMEOUT, 65535, cycles without any capture before a stall is flagged; legal range > SETTLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- seg_n  in  7  segment lines, active-low; bit order {g,f,e,d,c,b,a}, bit 0 = segment a.
- an_n  in  NUM_DIGITS  digit strobes, active-low, one-hot when valid; an_n[0] = rightmost digit.
- bcd_frame  out  4*NUM_DIGITS  decoded digits; digit i at bits [4i+3:4i].
- seg_err  out  NUM_DIGITS  per-digit flag: pattern in last frame was not a legal code.
- frame_valid  out  1  one-cycle pulse when bcd_frame/seg_err update.
- onehot_err  out  1  one-cycle pulse when registered an_n has more than one low bit.
- stall  out  1  level; no capture for TIMEOUT cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - bcd_frame = all 4'hF.
  - seg_err = 0.
  - frame_valid = 0.
  - onehot_err = 0.
  - stall = 0.
  - Internal sample registers reset to all ones (idle bus).
  - Stability counter, seen mask, capture-done flag and timeout counter reset to 0.
- Input stage: seg_n and an_n are registered once into r_seg/r_an every cycle. All logic operates on r_seg/r_an.
- Strobe classification of r_an:
  - All ones: idle; counter cleared.
  - Exactly one zero: valid; the low bit selects the digit index.
  - Two or more zeros: invalid; counter cleared and onehot_err pulses for every such cycle.
- Stability counter:
  - Increments (saturating at SETTLE) when r_an is valid and {r_an, r_seg} equals its value from the previous cycle.
  - Otherwise it is loaded with 1 if r_an is valid, or 0 if not.
- Capture:
  - Occurs on the cycle the counter becomes SETTLE while the capture-done flag is clear; the flag is then set.
  - Capture-done clears when {r_an, r_seg} changes.
  - Result: exactly one capture per stable strobe dwell.
- Decode table (r_seg -> BCD, seg_err bit):
  - 1000000 -> 0
  - 1111001 -> 1
  - 0100100 -> 2
  - 0110000 -> 3
  - 0011001 -> 4
  - 0010010 -> 5
  - 0000010 -> 6
  - 1111000 -> 7
  - 0000000 -> 8
  - 0010000 -> 9
  - 1111111 -> 4'hF, no error (blank).
  - Any other pattern -> 4'hE with the error bit set.
- Capture action:
  - Decoded nibble and error bit are written to a staging slot for the digit.
  - The digit's bit in the seen mask is set.
  - A re-capture of an already-seen digit before frame completion overwrites its slot.
- Frame completion:
  - On the cycle after the seen mask becomes all ones, staging is copied to bcd_frame/seg_err and frame_valid pulses for one cycle.
  - The seen mask is cleared on that same cycle.
  - A capture coinciding with the copy cycle belongs to the next frame.
- Stall:
  - The timeout counter clears on every capture; otherwise it increments, saturating.
  - When it reaches TIMEOUT, stall = 1 and the seen mask is cleared, discarding the partial frame.
  - stall drops on the next capture.
- Outputs hold their values between frames.
- Mid-operation rst: all state returns to reset values on the next edge and any partial frame is lost.

Test Plan:
- Reset, then scan digits 0..5 showing patterns for 1,2,3,4,5,6 (SETTLE+2 cycles each) -> exactly one frame_valid; bcd_frame = 24'h654321, seg_err = 0.
- Digit 2 driven 7'b1111111 (blank), the rest 0 -> bcd_frame nibble 2 = F, seg_err = 0.
- Digit 3 driven 7'b0101010 (illegal) -> nibble 3 = E, seg_err = 6'b001000.
- Strobe dwell of SETTLE-1 cycles on digit 4 throughout the scan -> no frame_valid. Lengthening the dwell to SETTLE -> frame_valid.
- an_n = 6'b111100 for 3 cycles -> onehot_err high for 3 cycles, no capture.
- Bus held idle for TIMEOUT cycles after 3 captures -> stall = 1, partial frame discarded. The next full scan yields frame_valid and stall = 0. Asserting rst mid-scan -> bcd_frame = all F, no frame_valid.
